i2s_rx_tdm_channel: RTL

- Parametrised TDM/DSP-mode serial audio receiver; successor to the two-channel DSP receiver.
- Captures up to MAX_SLOTS time slots per frame on NUM_LINES parallel data lines, with a configurable frame-sync offset, slot width, sample width, bit order and per-slot enable mask.
- Sits between the pads (via the existing clock inverter/mux, which selects the sampling edge upstream) and the uDMA RX channel.
- Output is a single valid/ready word stream, buffered by an internal FIFO.

---
 rtl/i2s_rx_tdm_channel.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_tdm_channel.sv
// i2s_rx_tdm_channel: TDM/DSP-mode serial audio receiver with per-slot mask and output FIFO.
// Ports:
//   sck_i, rst_i            bit clock (rising edge) and asynchronous active-high reset
//   sd_i, fs_i              serial data (one bit per line) and frame sync
//   cfg_*                   static configuration, sampled while busy_o=1
//   data_o, data_line_o,    received word stream (right-aligned sample, line and slot tags),
//   data_slot_o, valid_o,   valid while the output FIFO is non-empty, popped on ready_i
//   ready_i
//   overflow_o              sticky word-dropped flag, cleared by cfg_en_i=0
//   fs_err_o, done_o        one-cycle pulses: unexpected fs edge in RUN, capture finished
//   busy_o                  receiver not idle
// Optional feature: define I2S_RX_TDM_SIGN_EXT_EN to add cfg_sign_ext_i, which sign-extends
// each sample from bit cfg_num_bits_i instead of zero-filling the upper bits.
module i2s_rx_tdm_channel #(
    parameter int NUM_LINES  = 2,
    parameter int MAX_SLOTS  = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int SW = $clog2(MAX_SLOTS),
    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                 sck_i,
    input  logic                 rst_i,
    input  logic [NUM_LINES-1:0] sd_i,
    input  logic                 fs_i,
    input  logic                 cfg_en_i,
    input  logic [SW-1:0]        cfg_num_slots_i,
    input  logic [4:0]           cfg_slot_width_i,
    input  logic [4:0]           cfg_num_bits_i,
    input  logic                 cfg_lsb_first_i,
    input  logic [8:0]           cfg_offset_i,
    input  logic [MAX_SLOTS-1:0] cfg_slot_mask_i,
    input  logic                 cfg_continuous_i,
    input  logic [15:0]          cfg_num_frames_i,
`ifdef I2S_RX_TDM_SIGN_EXT_EN
    input  logic                 cfg_sign_ext_i,
`endif
    output logic [31:0]          data_o,
    output logic [LW-1:0]        data_line_o,
    output logic [SW-1:0]        data_slot_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overflow_o,
    output logic                 fs_err_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 32 + LW + SW;

    typedef enum logic [1:0] {IDLE, OFFSET, RUN, SYNC} state_t;

    state_t          state, state_nx;
    logic            fs_q, fs_rise;
    logic [8:0]      off_cnt;
    logic [4:0]      bit_cnt;
    logic [SW-1:0]   slot_cnt;
    logic [15:0]     frame_cnt;
    logic            halted;
    logic            sync_edge, fs_abort, start, take, frame_end, last_frame, capture;
    logic [4:0]      cur_bit;
    logic [SW-1:0]   cur_slot;
    logic            sign_ext;
    logic [31:0]     keep_mask;
    logic [31:0]     sr    [NUM_LINES];
    logic [31:0]     sr_nx [NUM_LINES];
    logic [31:0]     raw   [NUM_LINES];
    logic [31:0]     word  [NUM_LINES];
    logic [31:0]     hold  [NUM_LINES];
    logic [SW-1:0]   hold_slot;
    logic            drain_act;
    logic [LW-1:0]   drain_idx;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, pop, push_ok;

`ifdef I2S_RX_TDM_SIGN_EXT_EN
    assign sign_ext = cfg_sign_ext_i;
`else
    assign sign_ext = 1'b0;
`endif

    assign fs_rise = fs_i & ~fs_q;

    // state register
    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            fs_q  <= 1'b0;
        end else begin
            state <= state_nx;
            fs_q  <= fs_i;
        end
    end

    // next-state logic; an fs edge in RUN restarts offset handling just like SYNC
    always_comb begin
        state_nx = state;
        if (!cfg_en_i)
            state_nx = IDLE;
        else begin
            case (state)
                IDLE:    if (fs_rise && !halted) state_nx = (cfg_offset_i == '0) ? RUN : OFFSET;
                SYNC:    if (fs_rise) state_nx = (cfg_offset_i == '0) ? RUN : OFFSET;
                OFFSET:  if (off_cnt == cfg_offset_i) state_nx = RUN;
                RUN:     if (fs_rise) state_nx = (cfg_offset_i == '0) ? RUN : OFFSET;
                         else if (frame_end) state_nx = last_frame ? IDLE : SYNC;
                default: state_nx = IDLE;
            endcase
        end
    end

    // output / datapath control decode
    always_comb begin
        busy_o     = state != IDLE;
        sync_edge  = cfg_en_i && fs_rise &&
                     (state == SYNC || state == RUN || (state == IDLE && !halted));
        fs_abort   = cfg_en_i && fs_rise && state == RUN;
        // start: this edge carries bit 0 of slot 0
        start      = (sync_edge && cfg_offset_i == '0) ||
                     (cfg_en_i && state == OFFSET && off_cnt == cfg_offset_i);
        take       = start || (cfg_en_i && state == RUN && !fs_rise);
        cur_bit    = start ? 5'd0 : bit_cnt;
        cur_slot   = start ? '0 : slot_cnt;
        frame_end  = take && cur_slot == cfg_num_slots_i && cur_bit == cfg_slot_width_i;
        last_frame = !cfg_continuous_i && frame_cnt == cfg_num_frames_i;
        capture    = take && cur_bit == cfg_num_bits_i && cfg_slot_mask_i[cur_slot];
    end

    // per-line shift and word assembly; LSB-first data lands at the top and is shifted down
    always_comb begin
        keep_mask = 32'hFFFF_FFFF >> (5'd31 - cfg_num_bits_i);
        for (int k = 0; k < NUM_LINES; k++) begin
            sr_nx[k] = cfg_lsb_first_i ? {sd_i[k], sr[k][31:1]} : {sr[k][30:0], sd_i[k]};
            raw[k]   = (cfg_lsb_first_i ? sr_nx[k] >> (5'd31 - cfg_num_bits_i) : sr_nx[k]) & keep_mask;
            word[k]  = raw[k] | ((sign_ext && raw[k][cfg_num_bits_i]) ? ~keep_mask : 32'd0);
        end
    end

    // counters, re-arm latch and drain sequencer
    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            off_cnt   <= '0;
            bit_cnt   <= '0;
            slot_cnt  <= '0;
            frame_cnt <= '0;
            halted    <= 1'b0;
            drain_act <= 1'b0;
            drain_idx <= '0;
        end else if (!cfg_en_i) begin
            off_cnt   <= '0;
            bit_cnt   <= '0;
            slot_cnt  <= '0;
            frame_cnt <= '0;
            halted    <= 1'b0;
            drain_act <= 1'b0;
            drain_idx <= '0;
        end else begin
            off_cnt <= (state_nx == OFFSET) ? ((state == OFFSET) ? off_cnt + 9'd1 : 9'd1) : 9'd0;
            if (take) begin
                bit_cnt  <= (cur_bit == cfg_slot_width_i) ? 5'd0 : cur_bit + 5'd1;
                slot_cnt <= frame_end ? '0 :
                            (cur_bit == cfg_slot_width_i) ? cur_slot + SW'(1) : cur_slot;
            end else if (fs_abort) begin
                bit_cnt  <= '0;
                slot_cnt <= '0;
            end
            if (frame_end) frame_cnt <= last_frame ? 16'd0 : frame_cnt + 16'd1;
            // after a finite capture completes, only an enable toggle re-arms the receiver
            if (frame_end && last_frame) halted <= 1'b1;
            if (capture) begin
                drain_act <= 1'b1;
                drain_idx <= '0;
            end else if (drain_act) begin
                drain_act <= drain_idx != LW'(NUM_LINES - 1);
                drain_idx <= drain_idx + LW'(1);
            end
        end
    end

    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_LINES; k++) begin
                sr[k]   <= '0;
                hold[k] <= '0;
            end
            hold_slot <= '0;
        end else begin
            for (int k = 0; k < NUM_LINES; k++) begin
                if (take && cur_bit <= cfg_num_bits_i) sr[k] <= sr_nx[k];
                if (capture) hold[k] <= word[k];
            end
            if (capture) hold_slot <= cur_slot;
        end
    end

    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            done_o   <= 1'b0;
            fs_err_o <= 1'b0;
        end else begin
            done_o   <= frame_end && last_frame;
            fs_err_o <= fs_abort;
        end
    end

    // output FIFO; a push while full is accepted only when a pop frees a slot in the same cycle
    always_comb begin
        full    = count == (AW + 1)'(FIFO_DEPTH);
        valid_o = count != '0;
        pop     = valid_o && ready_i;
        push_ok = drain_act && (!full || pop);
        {data_o, data_line_o, data_slot_o} = valid_o ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge sck_i) begin
        if (push_ok) mem[wr_ptr] <= {hold[drain_idx], drain_idx, hold_slot};
    end

    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else if (!cfg_en_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
            if (drain_act && full && !pop) overflow_o <= 1'b1;
        end
    end
endmodule
